// File: rtl/rvv_pkg.sv
// Shared constants, types and helpers for the RVV destination-collect path.
package rvv_pkg;

  // Element width codes as carried on vsew.
  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
  localparam logic [2:0] SEW64 = 3'd3;

  // ALU result slot geometry.
  localparam int SLOT_W    = 64;
  localparam int NUM_SLOTS = 4;
  localparam int REGI_W    = 10;

  // Effective write width fits 8..64, so 7 bits.
  localparam int EW_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } coll_state_e;

  // Bits actually written per slot: the element width clamped to the lane width.
  function automatic logic [EW_W-1:0] eff_width(input logic [2:0] vsew, input int lane_width);
    logic [EW_W-1:0] sew_w;
    logic [EW_W-1:0] lane_w;
    case (vsew)
      SEW8:    sew_w = 7'd8;
      SEW16:   sew_w = 7'd16;
      SEW32:   sew_w = 7'd32;
      default: sew_w = 7'd64;
    endcase
    lane_w = 7'(1 << lane_width);
    return (sew_w < lane_w) ? sew_w : lane_w;
  endfunction

endpackage

// File: rtl/rvv_vd_scatter.sv
// Combinational masked insert of one result slot into the destination accumulator.
// A slot whose field would run past the top of the register is dropped and flagged.
module rvv_vd_scatter
  import rvv_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0]   i_acc,
  input  logic [SLOT_W-1:0] i_data,
  input  logic [REGI_W-1:0] i_offset,
  input  logic [EW_W-1:0]   i_width,
  input  logic              i_en,
  output logic [VLEN-1:0]   o_acc,
  output logic              o_wr,
  output logic              o_oob
);

  logic [SLOT_W-1:0] w_mask;
  logic [11:0]       w_end;
  logic              w_out_of_range;
  logic [VLEN-1:0]   w_mask_v;
  logic [VLEN-1:0]   w_data_v;

  assign w_mask         = (i_width >= 7'd64) ? '1 : ((64'd1 << i_width) - 64'd1);
  assign w_end          = 12'(i_offset) + 12'(i_width);
  assign w_out_of_range = (w_end > 12'(VLEN));

  assign o_wr  = i_en & ~w_out_of_range;
  assign o_oob = i_en &  w_out_of_range;

  assign w_mask_v = VLEN'(w_mask) << i_offset;
  assign w_data_v = VLEN'(i_data & w_mask) << i_offset;

  assign o_acc = o_wr ? ((i_acc & ~w_mask_v) | w_data_v) : i_acc;

endmodule

// File: rtl/rvv_vd_collector.sv
// Collects per-lane ALU results into a VLEN-wide destination register and
// offers the finished register to the VRF through a valid/ready handshake.
module rvv_vd_collector
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2:0]                    vsew,
  input  logic [NUM_SLOTS*SLOT_W-1:0]   vd_in,
  input  logic [NUM_SLOTS*REGI_W-1:0]   regi,
  input  logic [NUM_SLOTS-1:0]          res,
  input  logic                          done_in,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [VLEN-1:0]               vd_out,
  output logic                          busy,
  output logic [7:0]                    elem_cnt,
  output logic                          oob_err
);

  localparam int ACTIVE_SLOTS = 1 << NB_LANES;

  coll_state_e r_state;
  coll_state_e w_next_state;

  logic [2:0]      r_vsew_q;
  logic [VLEN-1:0] r_acc;
  logic [7:0]      r_elem_cnt;
  logic            r_oob;

  logic [EW_W-1:0]                 w_width;
  logic [NUM_SLOTS:0][VLEN-1:0]    w_acc_chain;
  logic [NUM_SLOTS-1:0]            w_slot_en;
  logic [NUM_SLOTS-1:0]            w_wr;
  logic [NUM_SLOTS-1:0]            w_oob;
  logic                            w_restart;
  logic                            w_collect;
  logic [8:0]                      w_cnt_sum;

  // A start is honoured everywhere except in HOLD, where the pending result must be taken first.
  assign w_restart = start & ((r_state != ST_HOLD) | wr_ready);
  // Beats land only in COLLECT and only when no restart is discarding them.
  assign w_collect = (r_state == ST_COLLECT) & ~start;

  assign w_width = eff_width(r_vsew_q, LANE_WIDTH);

  // Slots are chained 0..3 so a later slot at the same offset overwrites an earlier one.
  assign w_acc_chain[0] = r_acc;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign w_slot_en[k] = w_collect & res[k] & (k < ACTIVE_SLOTS);

    rvv_vd_scatter #(
      .VLEN (VLEN)
    ) u_scatter (
      .i_acc    (w_acc_chain[k]),
      .i_data   (vd_in[SLOT_W*k +: SLOT_W]),
      .i_offset (regi[REGI_W*k +: REGI_W]),
      .i_width  (w_width),
      .i_en     (w_slot_en[k]),
      .o_acc    (w_acc_chain[k+1]),
      .o_wr     (w_wr[k]),
      .o_oob    (w_oob[k])
    );
  end

  assign w_cnt_sum = {1'b0, r_elem_cnt} + 9'($countones(w_wr));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_COLLECT;
      ST_COLLECT: if (!start && done_in) w_next_state = ST_HOLD;
      ST_HOLD:    if (wr_ready) w_next_state = start ? ST_COLLECT : ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    wr_valid = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      ST_COLLECT: busy = 1'b1;
      ST_HOLD: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator, element counter, sticky error and latched element width.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the accumulator is reset because untouched bits must read back as zero.
    if (reset) begin
      r_acc      <= '0;
      r_elem_cnt <= '0;
      r_oob      <= 1'b0;
      r_vsew_q   <= SEW8;
    end else if (w_restart) begin
      r_acc      <= '0;
      r_elem_cnt <= '0;
      r_oob      <= 1'b0;
      r_vsew_q   <= vsew;
    end else if (w_collect) begin
      r_acc      <= w_acc_chain[NUM_SLOTS];
      r_elem_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
      r_oob      <= r_oob | (|w_oob);
    end
  end

  assign vd_out   = r_acc;
  assign elem_cnt = r_elem_cnt;
  assign oob_err  = r_oob;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed bench for rvv_vd_collector: a narrow-lane instance (8-bit lanes, 2 slots)
// and a wide-lane instance (64-bit lanes, 4 slots) driven with identical stimulus.
module tb_rvv_vd_collector;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   vsew;
  logic [255:0] vd_in;
  logic [39:0]  regi;
  logic [3:0]   res;
  logic         done_in;
  logic         wr_ready;

  logic         a_wr_valid, a_busy, a_oob;
  logic [127:0] a_vd;
  logic [7:0]   a_cnt;
  logic         b_wr_valid, b_busy, b_oob;
  logic [127:0] b_vd;
  logic [7:0]   b_cnt;

  int n_pass  = 0;
  int n_total = 0;

  rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew), .vd_in(vd_in), .regi(regi),
    .res(res), .done_in(done_in), .wr_valid(a_wr_valid), .wr_ready(wr_ready),
    .vd_out(a_vd), .busy(a_busy), .elem_cnt(a_cnt), .oob_err(a_oob)
  );

  rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(6), .NB_LANES(2)) u_dut_wide (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew), .vd_in(vd_in), .regi(regi),
    .res(res), .done_in(done_in), .wr_valid(b_wr_valid), .wr_ready(wr_ready),
    .vd_out(b_vd), .busy(b_busy), .elem_cnt(b_cnt), .oob_err(b_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   vsew;
    logic [3:0]   res;
    logic [63:0]  d0, d1, d2, d3;
    logic [9:0]   r0, r1, r2, r3;
    logic [127:0] a_vd;
    logic [7:0]   a_cnt;
    logic         a_oob;
    logic [127:0] b_vd;
    logic [7:0]   b_cnt;
    logic         b_oob;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start    = 1'b0;
    res      = '0;
    done_in  = 1'b0;
    wr_ready = 1'b0;
    vd_in    = '0;
    regi     = '0;
  endtask

  task automatic do_start(input logic [2:0] sew);
    start = 1'b1;
    vsew  = sew;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
  endtask

  logic [127:0] fill_exp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vsew = 3'd0;
    clear_in();
    reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset wr_valid", a_wr_valid, 1'b0);
    check("reset busy", a_busy, 1'b0);
    check("reset vd_out", a_vd, 128'h0);
    check("reset elem_cnt", a_cnt, 8'd0);
    check("reset oob_err", a_oob, 1'b0);

    // vsew, res, d0..d3, r0..r3, narrow {vd, cnt, oob}, wide {vd, cnt, oob}
    vecs[0] = '{3'd0, 4'b0001, 64'h1122334455667788, 64'h0, 64'h0, 64'h0,
                10'd0, 10'd0, 10'd0, 10'd0,
                128'h88, 8'd1, 1'b0, 128'h88, 8'd1, 1'b0};
    vecs[1] = '{3'd1, 4'b0011, 64'h1122334455667788, 64'hAAAABBBBCCCCDDDD, 64'h0, 64'h0,
                10'd16, 10'd40, 10'd0, 10'd0,
                128'h0000_0000_0000_0000_0000_DD00_0088_0000, 8'd2, 1'b0,
                128'h0000_0000_0000_0000_00DD_DD00_7788_0000, 8'd2, 1'b0};
    vecs[2] = '{3'd2, 4'b0011, 64'h00000000CAFEBABE, 64'h0000000012345678, 64'h0, 64'h0,
                10'd8, 10'd8, 10'd0, 10'd0,
                128'h7800, 8'd2, 1'b0, 128'h12_3456_7800, 8'd2, 1'b0};
    vecs[3] = '{3'd3, 4'b0100, 64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0,
                10'd0, 10'd0, 10'd64, 10'd0,
                128'h0, 8'd0, 1'b0,
                128'h0123_4567_89AB_CDEF_0000_0000_0000_0000, 8'd1, 1'b0};
    vecs[4] = '{3'd0, 4'b0011, 64'h5A, 64'hC3, 64'h0, 64'h0,
                10'd120, 10'd121, 10'd0, 10'd0,
                128'h5A00_0000_0000_0000_0000_0000_0000_0000, 8'd1, 1'b1,
                128'h5A00_0000_0000_0000_0000_0000_0000_0000, 8'd1, 1'b1};
    vecs[5] = '{3'd3, 4'b0001, 64'hFFFFFFFFFFFFFFAB, 64'h0, 64'h0, 64'h0,
                10'd0, 10'd0, 10'd0, 10'd0,
                128'hAB, 8'd1, 1'b0,
                128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFAB, 8'd1, 1'b0};
    vecs[6] = '{3'd0, 4'b0101, 64'h11, 64'h0, 64'h99, 64'h0,
                10'd4, 10'd0, 10'd124, 10'd0,
                128'h110, 8'd1, 1'b0, 128'h110, 8'd1, 1'b1};
    vecs[7] = '{3'd2, 4'b0010, 64'h0, 64'hDEADBEEF01020304, 64'h0, 64'h0,
                10'd0, 10'd96, 10'd0, 10'd0,
                128'h0000_0004_0000_0000_0000_0000_0000_0000, 8'd1, 1'b0,
                128'h0102_0304_0000_0000_0000_0000_0000_0000, 8'd1, 1'b0};

    // Single-beat transactions: start, one beat with done, inspect HOLD, accept.
    for (int i = 0; i < 8; i++) begin
      do_start(vecs[i].vsew);
      vd_in   = {vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0};
      regi    = {vecs[i].r3, vecs[i].r2, vecs[i].r1, vecs[i].r0};
      res     = vecs[i].res;
      done_in = 1'b1;
      tick();
      clear_in();
      check($sformatf("v%0d wr_valid", i), a_wr_valid, 1'b1);
      check($sformatf("v%0d vd_narrow", i), a_vd, vecs[i].a_vd);
      check($sformatf("v%0d cnt_narrow", i), a_cnt, vecs[i].a_cnt);
      check($sformatf("v%0d oob_narrow", i), a_oob, vecs[i].a_oob);
      check($sformatf("v%0d vd_wide", i), b_vd, vecs[i].b_vd);
      check($sformatf("v%0d cnt_wide", i), b_cnt, vecs[i].b_cnt);
      check($sformatf("v%0d oob_wide", i), b_oob, vecs[i].b_oob);
      accept();
      check($sformatf("v%0d idle busy", i), a_busy, 1'b0);
    end

    // 8-bit fill over eight beats.
    fill_exp = 128'h87178616851584148313821281118010;
    do_start(3'd0);
    for (int i = 0; i < 8; i++) begin
      vd_in   = {128'h0, 64'(8'h80 + i), 64'(8'h10 + i)};
      regi    = {20'h0, 10'(16 * i + 8), 10'(16 * i)};
      res     = 4'b0011;
      done_in = (i == 7);
      tick();
      if (i == 6) check("fill wr_valid before done", a_wr_valid, 1'b0);
    end
    clear_in();
    check("fill wr_valid", a_wr_valid, 1'b1);
    check("fill vd_out", a_vd, fill_exp);
    check("fill elem_cnt", a_cnt, 8'd16);
    check("fill vd_wide", b_vd, fill_exp);

    // Backpressure: five cycles without ready, a stray start and stray beats.
    for (int c = 0; c < 5; c++) begin
      start   = (c == 2);
      res     = 4'b1111;
      done_in = 1'b1;
      vd_in   = '1;
      regi    = '0;
      tick();
      check($sformatf("bp%0d wr_valid", c), a_wr_valid, 1'b1);
      check($sformatf("bp%0d vd_out", c), a_vd, fill_exp);
    end
    clear_in();
    check("bp elem_cnt", a_cnt, 8'd16);
    accept();
    check("bp accepted wr_valid", a_wr_valid, 1'b0);
    check("bp accepted busy", a_busy, 1'b0);

    // Restart mid-collection drops the partial result and the same-cycle beat.
    do_start(3'd0);
    vd_in = {128'h0, 64'h44, 64'h33};
    regi  = {20'h0, 10'd16, 10'd8};
    res   = 4'b0011;
    tick();
    tick();
    start = 1'b1;
    res   = 4'b0001;
    vd_in = {192'h0, 64'hEE};
    regi  = '0;
    tick();
    clear_in();
    check("restart busy", a_busy, 1'b1);
    check("restart vd_out", a_vd, 128'h0);
    check("restart elem_cnt", a_cnt, 8'd0);
    res     = 4'b0001;
    vd_in   = {192'h0, 64'h5A};
    done_in = 1'b1;
    tick();
    clear_in();
    check("restart final wr_valid", a_wr_valid, 1'b1);
    check("restart final vd_out", a_vd, 128'h5A);
    check("restart final elem_cnt", a_cnt, 8'd1);

    // Asynchronous reset while holding a result, checked before the next edge.
    #2 reset = 1'b1;
    #1;
    check("async reset wr_valid", a_wr_valid, 1'b0);
    check("async reset busy", a_busy, 1'b0);
    check("async reset vd_out", a_vd, 128'h0);
    check("async reset vd_wide", b_vd, 128'h0);
    tick();
    reset = 1'b0;
    tick();

    // Start and done together in COLLECT: start wins.
    do_start(3'd0);
    start   = 1'b1;
    done_in = 1'b1;
    res     = 4'b0001;
    vd_in   = {192'h0, 64'h77};
    tick();
    clear_in();
    check("start+done wr_valid", a_wr_valid, 1'b0);
    check("start+done busy", a_busy, 1'b1);
    check("start+done vd_out", a_vd, 128'h0);
    res     = 4'b0001;
    vd_in   = {192'h0, 64'h42};
    done_in = 1'b1;
    tick();
    clear_in();
    check("start+done final vd_out", a_vd, 128'h42);

    // Accept and start in the same HOLD cycle go straight back to COLLECT.
    wr_ready = 1'b1;
    start    = 1'b1;
    vsew     = 3'd0;
    tick();
    clear_in();
    check("accept+start wr_valid", a_wr_valid, 1'b0);
    check("accept+start busy", a_busy, 1'b1);
    check("accept+start vd_out", a_vd, 128'h0);
    done_in = 1'b1;
    tick();
    clear_in();
    accept();

    // Element counter saturation: 70 beats of every slot.
    do_start(3'd0);
    res  = 4'b1111;
    for (int i = 0; i < 70; i++) begin
      done_in = (i == 69);
      tick();
    end
    clear_in();
    check("sat cnt_narrow", a_cnt, 8'd140);
    check("sat cnt_wide", b_cnt, 8'd255);
    accept();

    // IDLE ignores beats and done.
    res     = 4'b0001;
    vd_in   = {192'h0, 64'hFF};
    done_in = 1'b1;
    tick();
    clear_in();
    check("idle busy", a_busy, 1'b0);
    check("idle wr_valid", a_wr_valid, 1'b0);
    check("idle vd_out", a_vd, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
